// File: rtl/acc_fork_join.sv
// acc_fork_join_fifo: small generic FIFO with occupancy count; the mask FIFO of the fork/join is one of these.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push_vld is ignored while full; pop_rdy is ignored while empty.
//
// acc_fork_join: broadcasts one request stream to NrClusters channels and joins their responses in order.
// Latency: 1 cycle from accept to req_valid_o; 1 cycle from the last response capture to resp_valid_o.
// Backpressure: req_ready_o drops while any selected cluster has yet to take the request,
//                while MaxOutstanding requests await a join, or while the cluster mask is zero.
//
// Ports (acc_fork_join):
//   cluster_mask_i                  participating clusters, sampled only at request accept
//   req_valid_i/req_ready_o/req_data_i     upstream request handshake and payload
//   req_valid_o/req_ready_i/req_data_o     per-cluster request handshakes, shared payload
//   resp_valid_i/resp_ready_o/resp_data_i/resp_err_i   per-cluster responses
//   resp_valid_o/resp_ready_i/resp_data_o/resp_err_o   merged, in-order response
//   outstanding_o                   accepted requests not yet joined

module acc_fork_join_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_vld,
    input  logic [Width-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic                       head_vld,
    output logic [Width-1:0]           head_dat,
    output logic                       full,
    output logic [$clog2(Depth+1)-1:0] count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_fire, pop_fire;

    assign full      = (count_q == FullCnt);
    assign head_vld  = (count_q != '0);
    assign head_dat  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign push_fire = push_vld && !full;
    assign pop_fire  = pop_rdy && head_vld;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_dat;
            // Depth need not be a power of two, so wrap explicitly.
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module acc_fork_join #(
    parameter int NrClusters     = 4,
    parameter int ReqWidth       = 64,
    parameter int RespWidth      = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrClusters-1:0]               cluster_mask_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [ReqWidth-1:0]                 req_data_i,
    output logic [NrClusters-1:0]               req_valid_o,
    input  logic [NrClusters-1:0]               req_ready_i,
    output logic [ReqWidth-1:0]                 req_data_o,
    input  logic [NrClusters-1:0]               resp_valid_i,
    output logic [NrClusters-1:0]               resp_ready_o,
    input  logic [NrClusters*RespWidth-1:0]     resp_data_i,
    input  logic [NrClusters-1:0]               resp_err_i,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic [RespWidth-1:0]                resp_data_o,
    output logic                                resp_err_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);
    logic [NrClusters-1:0] pending_q, pending_d, pending_next;
    logic [ReqWidth-1:0]   req_data_q, req_data_d;
    logic [NrClusters-1:0] held_q, held_d;
    logic [NrClusters-1:0] err_q, err_d;
    logic [RespWidth-1:0]  data_q [NrClusters];
    logic [RespWidth-1:0]  data_d [NrClusters];
    logic [NrClusters-1:0] head_mask;
    logic                  fifo_nonempty, fifo_full;
    logic                  accept, join_hs;

    // ---------------- fork ----------------
    // Looking through this cycle's cluster handshakes lets a new request be
    // accepted in the same cycle the last selected cluster takes the old one.
    assign pending_next = pending_q & ~req_ready_i;
    assign req_ready_o  = (pending_next == '0) && !fifo_full && (cluster_mask_i != '0);
    assign accept       = req_valid_i && req_ready_o;
    assign req_valid_o  = pending_q;
    assign req_data_o   = req_data_q;

    always_comb begin
        pending_d  = pending_next;
        req_data_d = req_data_q;
        if (accept) begin
            pending_d  = cluster_mask_i;
            req_data_d = req_data_i;
        end
    end

    // The FIFO occupancy is exactly the number of requests awaiting a join.
    acc_fork_join_fifo #(
        .Width (NrClusters),
        .Depth (MaxOutstanding)
    ) u_mask_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (accept),
        .push_dat (cluster_mask_i),
        .pop_rdy  (join_hs),
        .head_vld (fifo_nonempty),
        .head_dat (head_mask),
        .full     (fifo_full),
        .count    (outstanding_o)
    );

    // ---------------- join ----------------
    assign resp_ready_o = ~held_q;
    assign resp_valid_o = fifo_nonempty && ((held_q & head_mask) == head_mask);
    assign join_hs      = resp_valid_o && resp_ready_i;
    assign resp_err_o   = |(err_q & head_mask);

    // Lowest-index participating cluster supplies the merged payload.
    always_comb begin
        resp_data_o = '0;
        for (int i = NrClusters - 1; i >= 0; i--) begin
            if (head_mask[i]) resp_data_o = data_q[i];
        end
    end

    // A join only clears bits that are held, and captures only happen into
    // bits that are not held, so the two updates never touch the same bit.
    always_comb begin
        held_d = held_q;
        err_d  = err_q;
        data_d = data_q;
        if (join_hs) held_d = held_q & ~head_mask;
        for (int i = 0; i < NrClusters; i++) begin
            if (resp_valid_i[i] && !held_q[i]) begin
                held_d[i] = 1'b1;
                err_d[i]  = resp_err_i[i];
                data_d[i] = resp_data_i[i*RespWidth +: RespWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= '0;
            req_data_q <= '0;
            held_q     <= '0;
            err_q      <= '0;
            for (int i = 0; i < NrClusters; i++) data_q[i] <= '0;
        end else begin
            pending_q  <= pending_d;
            req_data_q <= req_data_d;
            held_q     <= held_d;
            err_q      <= err_d;
            data_q     <= data_d;
        end
    end
endmodule

// File: tb/tb_acc_fork_join.sv
// tb_acc_fork_join: cycle-by-cycle directed vectors for acc_fork_join plus a reset sequence.
// Latency: each vector is one clock; outputs are compared 1 time unit after the falling edge drive.
// Backpressure: exercised through req_ready_i, resp_ready_i and the outstanding limit in the vectors.

module tb_acc_fork_join;
    localparam int NC = 4;
    localparam int QW = 64;
    localparam int RW = 64;
    localparam int MO = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NC-1:0]   cluster_mask_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [QW-1:0]   req_data_i;
    logic [NC-1:0]   req_valid_o;
    logic [NC-1:0]   req_ready_i;
    logic [QW-1:0]   req_data_o;
    logic [NC-1:0]   resp_valid_i;
    logic [NC-1:0]   resp_ready_o;
    logic [NC*RW-1:0] resp_data_i;
    logic [NC-1:0]   resp_err_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [RW-1:0]   resp_data_o;
    logic            resp_err_o;
    logic [2:0]      outstanding_o;

    acc_fork_join #(
        .NrClusters     (NC),
        .ReqWidth       (QW),
        .RespWidth      (RW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cluster_mask_i (cluster_mask_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_data_i     (req_data_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_data_o     (req_data_o),
        .resp_valid_i   (resp_valid_i),
        .resp_ready_o   (resp_ready_o),
        .resp_data_i    (resp_data_i),
        .resp_err_i     (resp_err_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_data_o    (resp_data_o),
        .resp_err_o     (resp_err_o),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    // One record per clock: inputs, then the outputs expected before the edge.
    // sd packs one byte per cluster (cluster 0 in the low byte).
    typedef struct packed {
        logic [3:0]  mask;
        logic        rv;
        logic [7:0]  rd;
        logic [3:0]  rr;
        logic [3:0]  sv;
        logic [31:0] sd;
        logic [3:0]  se;
        logic        ordy;
        logic        e_rr;
        logic [3:0]  e_qv;
        logic [7:0]  e_qd;
        logic [3:0]  e_sr;
        logic        e_sv;
        logic [7:0]  e_sd;
        logic        e_se;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic [3:0] mask, input logic rv, input logic [7:0] rd, input logic [3:0] rr,
        input logic [3:0] sv, input logic [31:0] sd, input logic [3:0] se, input logic ordy,
        input logic e_rr, input logic [3:0] e_qv, input logic [7:0] e_qd, input logic [3:0] e_sr,
        input logic e_sv, input logic [7:0] e_sd, input logic e_se, input logic [2:0] e_cnt);
        vec_t v;
        v.mask = mask; v.rv = rv; v.rd = rd; v.rr = rr; v.sv = sv; v.sd = sd; v.se = se; v.ordy = ordy;
        v.e_rr = e_rr; v.e_qv = e_qv; v.e_qd = e_qd; v.e_sr = e_sr;
        v.e_sv = e_sv; v.e_sd = e_sd; v.e_se = e_se; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got 0x%0h, want 0x%0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cluster_mask_i = v.mask;
        req_valid_i    = v.rv;
        req_data_i     = 64'(v.rd);
        req_ready_i    = v.rr;
        resp_valid_i   = v.sv;
        resp_err_i     = v.se;
        resp_ready_i   = v.ordy;
        for (int i = 0; i < NC; i++) resp_data_i[i*RW +: RW] = 64'(v.sd[i*8 +: 8]);
    endtask

    task automatic check_row(input int row, input vec_t v);
        chk("req_ready_o",   row, 64'(req_ready_o),   64'(v.e_rr));
        chk("req_valid_o",   row, 64'(req_valid_o),   64'(v.e_qv));
        chk("resp_ready_o",  row, 64'(resp_ready_o),  64'(v.e_sr));
        chk("resp_valid_o",  row, 64'(resp_valid_o),  64'(v.e_sv));
        chk("outstanding_o", row, 64'(outstanding_o), 64'(v.e_cnt));
        if (v.e_qv != 4'h0) chk("req_data_o", row, req_data_o, 64'(v.e_qd));
        if (v.e_sv) begin
            chk("resp_data_o", row, resp_data_o, 64'(v.e_sd));
            chk("resp_err_o",  row, 64'(resp_err_o), 64'(v.e_se));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // mask rv rd rr sv sd se ordy | e_rr e_qv e_qd e_sr e_sv e_sd e_se e_cnt
        // zero mask stalls; full broadcast and join (0xA5, responses 0x10+i)
        vecs.push_back(mk(4'h0,1'b1,8'h99,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b0,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        vecs.push_back(mk(4'hF,1'b1,8'hA5,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'hF,8'hA5,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'h13121110,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'h10,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        // staggered cluster accept, back-to-back accept on the last one
        vecs.push_back(mk(4'hF,1'b1,8'h21,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        vecs.push_back(mk(4'hF,1'b1,8'h22,4'h1,4'h0,32'h0,4'h0,1'b1, 1'b0,4'hF,8'h21,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b1,8'h22,4'h4,4'h0,32'h0,4'h0,1'b1, 1'b0,4'hE,8'h21,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b1,8'h22,4'hA,4'h0,32'h0,4'h0,1'b1, 1'b1,4'hA,8'h21,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'hF,8'h22,4'hF,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'h33323130,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'h43424140,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'h30,1'b0,3'd2));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'h43424140,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'h40,1'b0,3'd1));
        // partial mask 0110, cluster 2 error, cluster 1 supplies data
        vecs.push_back(mk(4'h6,1'b1,8'h3C,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        vecs.push_back(mk(4'h6,1'b0,8'h00,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h6,8'h3C,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'h6,1'b0,8'h00,4'h0,4'h6,32'h00557700,4'h4,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'h6,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h9,1'b1,8'h77,1'b1,3'd1));
        // outstanding limit, stall at 4, accept after a join, accept+join together
        vecs.push_back(mk(4'hF,1'b1,8'h01,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        vecs.push_back(mk(4'hF,1'b1,8'h02,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'hF,8'h01,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b1,8'h03,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'hF,8'h02,4'hF,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'hF,1'b1,8'h04,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b1,4'hF,8'h03,4'hF,1'b0,8'h00,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b1,8'h05,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b0,4'hF,8'h04,4'hF,1'b0,8'h00,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b1,8'h05,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b0,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b1,8'h05,4'h0,4'hF,32'h53525150,4'h0,1'b1, 1'b0,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b1,8'h05,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b0,4'h0,8'h00,4'h0,1'b1,8'h50,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b1,8'h05,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'hF,4'hF,32'h63626160,4'h0,1'b1, 1'b0,4'hF,8'h05,4'hF,1'b0,8'h00,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b0,4'h0,8'h00,4'h0,1'b1,8'h60,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b1,8'h06,4'hF,4'hF,32'h73727170,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'hF,4'h0,32'h0,4'h0,1'b1, 1'b0,4'hF,8'h06,4'h0,1'b1,8'h70,1'b0,3'd4));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'h83828180,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b1,8'h08,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'h80,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'hF,4'hF,32'h93929190,4'h0,1'b0, 1'b1,4'hF,8'h08,4'hF,1'b0,8'h00,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b0, 1'b1,4'h0,8'h00,4'h0,1'b1,8'h90,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'h90,1'b0,3'd3));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'hA3A2A1A0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'hA0,1'b0,3'd2));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'hD3D2D1D0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'h0,1'b1,8'hD0,1'b0,3'd1));
        // ordering: masks 0011 then 0001, early second cluster-0 response is backpressured
        vecs.push_back(mk(4'h3,1'b1,8'h51,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));
        vecs.push_back(mk(4'h1,1'b1,8'h52,4'h3,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h3,8'h51,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h1,4'h1,32'h000000B0,4'h0,1'b1, 1'b1,4'h1,8'h52,4'hF,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h1,32'h000000B1,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hE,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h1,32'h000000B1,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hE,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h3,32'h0000C0B1,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hE,1'b0,8'h00,1'b0,3'd2));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h1,32'h000000B1,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hC,1'b1,8'hB0,1'b0,3'd2));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h1,32'h000000B1,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd1));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hE,1'b1,8'hB1,1'b0,3'd1));
        vecs.push_back(mk(4'h1,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b1, 1'b1,4'h0,8'h00,4'hF,1'b0,8'h00,1'b0,3'd0));

        // reset state
        rst_ni = 1'b0;
        drive(mk(4'h0,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b0, 1'b0,4'h0,8'h00,4'h0,1'b0,8'h00,1'b0,3'd0));
        #12;
        chk("reset req_valid_o",   900, 64'(req_valid_o),   64'h0);
        chk("reset resp_ready_o",  900, 64'(resp_ready_o),  64'hF);
        chk("reset resp_valid_o",  900, 64'(resp_valid_o),  64'h0);
        chk("reset outstanding_o", 900, 64'(outstanding_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk_i);
            drive(vecs[r]);
            #1;
            check_row(r, vecs[r]);
        end

        // reset with two requests outstanding and held responses
        @(negedge clk_i);
        drive(mk(4'hF,1'b1,8'hE1,4'h0,4'h0,32'h0,4'h0,1'b0, 1'b0,4'h0,8'h00,4'h0,1'b0,8'h00,1'b0,3'd0));
        #1 chk("rst seq accept 1", 901, 64'(req_ready_o), 64'h1);
        @(negedge clk_i);
        drive(mk(4'hF,1'b1,8'hE2,4'hF,4'h0,32'h0,4'h0,1'b0, 1'b0,4'h0,8'h00,4'h0,1'b0,8'h00,1'b0,3'd0));
        #1 chk("rst seq accept 2", 902, 64'(req_ready_o), 64'h1);
        @(negedge clk_i);
        drive(mk(4'hF,1'b0,8'h00,4'h0,4'hF,32'hE3E2E1E0,4'h0,1'b0, 1'b0,4'h0,8'h00,4'h0,1'b0,8'h00,1'b0,3'd0));
        @(negedge clk_i);
        drive(mk(4'hF,1'b0,8'h00,4'h0,4'h0,32'h0,4'h0,1'b0, 1'b0,4'h0,8'h00,4'h0,1'b0,8'h00,1'b0,3'd0));
        #1;
        chk("pre-reset outstanding_o", 903, 64'(outstanding_o), 64'h2);
        chk("pre-reset resp_valid_o",  903, 64'(resp_valid_o),  64'h1);
        chk("pre-reset req_valid_o",   903, 64'(req_valid_o),   64'hF);
        rst_ni = 1'b0;
        #1;
        chk("mid-reset req_valid_o",   904, 64'(req_valid_o),   64'h0);
        chk("mid-reset resp_valid_o",  904, 64'(resp_valid_o),  64'h0);
        chk("mid-reset resp_ready_o",  904, 64'(resp_ready_o),  64'hF);
        chk("mid-reset outstanding_o", 904, 64'(outstanding_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("post-reset req_valid_o",   905, 64'(req_valid_o),   64'h0);
        chk("post-reset resp_valid_o",  905, 64'(resp_valid_o),  64'h0);
        chk("post-reset resp_ready_o",  905, 64'(resp_ready_o),  64'hF);
        chk("post-reset outstanding_o", 905, 64'(outstanding_o), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
